perf_event_counters: RTL

Synthesizable bank of parametrised event counters that moves the processor's instruction, cache-request and cache-hit statistics out of the simulation bench and into hardware. Sits beside the processor core and samples one-bit event strobes every clock: retired instruction, I-cache request/hit, D-cache request/hit, and others. Keeps a free-running cycle count, freezes all counts when the processor halts, and exposes a registered read port so the bench or a debug path can read any count after the program ends.

---
 rtl/perf_event_counters.sv | 128 ++++++++++++
 1 files changed

// File: rtl/perf_event_counters.sv
// perf_event_counters
// Bank of event counters plus a free-running cycle counter. Counting stops
// for good once a halt is captured (until rst or clear), so the counts can be
// read back through the registered read port after the program ends.
module perf_event_counters #(
  parameter int NUM_EVENTS = 8,
  parameter int CNT_WIDTH  = 32,
  parameter int SATURATE   = 1,
  parameter int SEL_W      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [NUM_EVENTS-1:0] event_in,
  input  logic                  halt,
  input  logic                  clear,
  input  logic [SEL_W-1:0]      rd_sel,
  output logic [CNT_WIDTH-1:0]  rd_data,
  output logic [CNT_WIDTH-1:0]  cycle_count,
  output logic                  frozen,
  output logic [NUM_EVENTS-1:0] overflow
);

  localparam logic [CNT_WIDTH-1:0] ALL_ONES  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] ZERO      = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] ONE       = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0]     CYCLE_SEL = SEL_W'(NUM_EVENTS);

  // A counter overflows when it is incremented while already all-ones.
  function automatic logic isMaxed(input logic [CNT_WIDTH-1:0] value);
    isMaxed = (value == ALL_ONES);
  endfunction

  // Increment with the configured overflow behaviour (stick or wrap).
  function automatic logic [CNT_WIDTH-1:0] bumpValue(input logic [CNT_WIDTH-1:0] value);
    if (isMaxed(value)) begin
      bumpValue = (SATURATE != 32'sd0) ? ALL_ONES : ZERO;
    end else begin
      bumpValue = value + ONE;
    end
  endfunction

  logic [CNT_WIDTH-1:0]  eventCnt_r [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  cycleCnt_r;
  logic [NUM_EVENTS-1:0] overflow_r;
  logic                  frozen_r;
  logic [CNT_WIDTH-1:0]  rdData_r;

  logic                  countActive_s;
  logic [CNT_WIDTH-1:0]  nextEventCnt_s [NUM_EVENTS];
  logic [CNT_WIDTH-1:0]  nextCycleCnt_s;
  logic [NUM_EVENTS-1:0] nextOverflow_s;
  logic                  nextFrozen_s;
  logic [CNT_WIDTH-1:0]  rdMux_s;

  assign countActive_s = enable & ~frozen_r;

  // Per-channel next counts and sticky overflow flags while counting is active.
  always_comb begin
    nextOverflow_s = overflow_r;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      if (countActive_s && event_in[i]) begin
        nextEventCnt_s[i] = bumpValue(eventCnt_r[i]);
        nextOverflow_s[i] = overflow_r[i] | isMaxed(eventCnt_r[i]);
      end else begin
        nextEventCnt_s[i] = eventCnt_r[i];
        nextOverflow_s[i] = overflow_r[i];
      end
    end
  end

  // Cycle counter advances and halt is captured only while counting is active;
  // once frozen, the freeze holds regardless of enable or halt.
  always_comb begin
    if (countActive_s) begin
      nextCycleCnt_s = bumpValue(cycleCnt_r);
      nextFrozen_s   = halt;
    end else begin
      nextCycleCnt_s = cycleCnt_r;
      nextFrozen_s   = frozen_r;
    end
  end

  // Read mux over the pre-update counts; unused selects read zero.
  always_comb begin
    rdMux_s = ZERO;
    for (int i = 0; i < NUM_EVENTS; i++) begin
      rdMux_s = (rd_sel == SEL_W'(i)) ? eventCnt_r[i] : rdMux_s;
    end
    rdMux_s = (rd_sel == CYCLE_SEL) ? cycleCnt_r : rdMux_s;
  end

  // State update: rst beats clear, clear beats counting; read data follows rd_sel
  // in every state except reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        eventCnt_r[i] <= ZERO;
      end
      cycleCnt_r <= ZERO;
      overflow_r <= {NUM_EVENTS{1'b0}};
      frozen_r   <= 1'b0;
      rdData_r   <= ZERO;
    end else if (clear) begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        eventCnt_r[i] <= ZERO;
      end
      cycleCnt_r <= ZERO;
      overflow_r <= {NUM_EVENTS{1'b0}};
      frozen_r   <= 1'b0;
      rdData_r   <= rdMux_s;
    end else begin
      for (int i = 0; i < NUM_EVENTS; i++) begin
        eventCnt_r[i] <= nextEventCnt_s[i];
      end
      cycleCnt_r <= nextCycleCnt_s;
      overflow_r <= nextOverflow_s;
      frozen_r   <= nextFrozen_s;
      rdData_r   <= rdMux_s;
    end
  end

  assign rd_data     = rdData_r;
  assign cycle_count = cycleCnt_r;
  assign frozen      = frozen_r;
  assign overflow    = overflow_r;

endmodule
